uart_rom_loader: RTL and testbench

- Writer side of the instruction ROM. Receives a program image over a UART RX line, assembles 32-bit words, and writes them into the ROM write port.
- Holds the core during the load and pulses the core reset afterwards, so software boots without a file-based ROM preload.
- Sits in risc_v_soc beside the ROM. Its hold output is ORed with the external hold.

---
 rtl/uart_rom_loader.sv | 324 ++++++++++++++++++++++++++++++++
 tb/tb_uart_rom_loader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rom_loader.sv
// uart_rom_loader
// Writer side of the instruction ROM. Receives a program image over a UART
// RX line, assembles little-endian 32-bit words and writes them through the
// ROM write port. It holds the core for the whole load. After a good load it
// pulses the core reset so software boots from the freshly written image.
//
// Frame: 0xA5 | count lo | count hi | N x 4 data bytes | [checksum]
//
// Optional build macro LOADER_CSUM_EN: when defined, a checksum byte follows
// the data. That byte must equal the XOR of all count and data bytes, or the
// frame is aborted.
//
// Ports:
//   clk_100MHz  system clock
//   arst_n      synchronous active-low reset (historical name)
//   uart_rx     asynchronous serial input, idle high
//   rom_we      one-cycle ROM write strobe per word
//   rom_waddr   ROM word address
//   rom_wdata   ROM write data
//   hold        stall request to the core (active during a frame)
//   core_rst_n  active-low core reset, pulsed for RST_CYC cycles after a load
//   busy        frame in progress
//   done        sticky: last frame loaded OK
//   err         sticky: last frame aborted
module uart_rom_loader #(
  parameter int unsigned CLK_FREQ    = 100000000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned TIMEOUT_CYC = 1000000,
  parameter int unsigned RST_CYC     = 8
) (
  input  logic              clk_100MHz,
  input  logic              arst_n,
  input  logic              uart_rx,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_waddr,
  output logic [31:0]       rom_wdata,
  output logic              hold,
  output logic              core_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned CPB   = CLK_FREQ / BAUD;
  localparam int unsigned HALF  = CPB / 2;
  localparam int unsigned BC_W  = $clog2(CPB + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned RC_W  = $clog2(RST_CYC + 1);
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  // ---------------- RX front end ----------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t       rx_state, rx_state_nx;
  logic [1:0]      rx_sync;
  logic            rx_prev;
  logic [BC_W-1:0] rx_cnt, rx_cnt_nx;
  logic [2:0]      rx_bit, rx_bit_nx;
  logic [7:0]      rx_byte, rx_byte_nx;
  logic            rx_valid, rx_valid_nx;
  logic            rx_err, rx_err_nx;
  logic            rx_in;

  assign rx_in = rx_sync[1];

  always_ff @(posedge clk_100MHz) begin
    if (!arst_n) begin
      rx_sync  <= 2'b11;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
    end else begin
      rx_sync  <= {rx_sync[0], uart_rx};
      rx_prev  <= rx_in;
      rx_state <= rx_state_nx;
      rx_cnt   <= rx_cnt_nx;
      rx_bit   <= rx_bit_nx;
      rx_byte  <= rx_byte_nx;
      rx_valid <= rx_valid_nx;
      rx_err   <= rx_err_nx;
    end
  end

  // Sampling points: mid start bit (HALF after the edge), then every CPB.
  always_comb begin
    rx_state_nx = rx_state;
    rx_cnt_nx   = rx_cnt + BC_W'(1);
    rx_bit_nx   = rx_bit;
    rx_byte_nx  = rx_byte;
    rx_valid_nx = 1'b0;
    rx_err_nx   = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_nx = '0;
        if (rx_prev && !rx_in) rx_state_nx = RX_START;
      end
      RX_START: begin
        if (rx_cnt == BC_W'(HALF - 1)) begin
          rx_cnt_nx   = '0;
          rx_bit_nx   = '0;
          // A line already back high is a glitch, not a start bit.
          rx_state_nx = rx_in ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt == BC_W'(CPB - 1)) begin
          rx_cnt_nx  = '0;
          rx_byte_nx = {rx_in, rx_byte[7:1]};
          rx_bit_nx  = rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_state_nx = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt == BC_W'(CPB - 1)) begin
          rx_state_nx = RX_IDLE;
          rx_valid_nx = rx_in;
          rx_err_nx   = !rx_in;
        end
      end
      default: rx_state_nx = RX_IDLE;
    endcase
  end

  // ---------------- Loader FSM ----------------
  typedef enum logic [2:0] {
    L_IDLE, L_CNT_LO, L_CNT_HI, L_DATA,
`ifdef LOADER_CSUM_EN
    L_CSUM,
`endif
    L_BOOT
  } ld_state_t;

  ld_state_t         state, state_nx;
  logic [7:0]        cnt_lo, cnt_lo_nx;
  logic [ADDR_W-1:0] last_idx, last_idx_nx;
  logic [1:0]        byte_idx, byte_idx_nx;
  logic [23:0]       asm_q, asm_nx;
  logic [TO_W-1:0]   to_cnt, to_cnt_nx;
  logic [RC_W-1:0]   boot_cnt, boot_cnt_nx;
  logic              we_nx, hold_nx, core_rst_n_nx, busy_nx, done_nx, err_nx;
  logic [ADDR_W-1:0] waddr_nx;
  logic [31:0]       wdata_nx;
  logic [15:0]       n_rx;
  logic              active, timeout, abort, frame_end, go_boot;
`ifdef LOADER_CSUM_EN
  logic [7:0]        csum_q, csum_nx;
`endif

  always_ff @(posedge clk_100MHz) begin
    if (!arst_n) begin
      state      <= L_IDLE;
      cnt_lo     <= '0;
      last_idx   <= '0;
      byte_idx   <= '0;
      asm_q      <= '0;
      to_cnt     <= '0;
      boot_cnt   <= '0;
      rom_we     <= 1'b0;
      rom_waddr  <= '0;
      rom_wdata  <= '0;
      hold       <= 1'b0;
      core_rst_n <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
`ifdef LOADER_CSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state      <= state_nx;
      cnt_lo     <= cnt_lo_nx;
      last_idx   <= last_idx_nx;
      byte_idx   <= byte_idx_nx;
      asm_q      <= asm_nx;
      to_cnt     <= to_cnt_nx;
      boot_cnt   <= boot_cnt_nx;
      rom_we     <= we_nx;
      rom_waddr  <= waddr_nx;
      rom_wdata  <= wdata_nx;
      hold       <= hold_nx;
      core_rst_n <= core_rst_n_nx;
      busy       <= busy_nx;
      done       <= done_nx;
      err        <= err_nx;
`ifdef LOADER_CSUM_EN
      csum_q     <= csum_nx;
`endif
    end
  end

  always_comb begin
    state_nx      = state;
    cnt_lo_nx     = cnt_lo;
    last_idx_nx   = last_idx;
    byte_idx_nx   = byte_idx;
    asm_nx        = asm_q;
    to_cnt_nx     = '0;
    boot_cnt_nx   = boot_cnt;
    we_nx         = 1'b0;
    waddr_nx      = rom_waddr;
    wdata_nx      = rom_wdata;
    hold_nx       = hold;
    core_rst_n_nx = core_rst_n;
    busy_nx       = busy;
    done_nx       = done;
    err_nx        = err;
`ifdef LOADER_CSUM_EN
    csum_nx       = csum_q;
`endif
    n_rx      = {rx_byte, cnt_lo};
    abort     = 1'b0;
    frame_end = 1'b0;
    go_boot   = 1'b0;
    active    = (state != L_IDLE) && (state != L_BOOT);
    // Timeout is checked without regard to rx_valid so it wins a tie.
    timeout   = active && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
    if (active && !rx_valid) to_cnt_nx = to_cnt + TO_W'(1);

    case (state)
      L_IDLE: begin
        if (rx_valid && rx_byte == 8'hA5) begin
          state_nx = L_CNT_LO;
          busy_nx  = 1'b1;
          hold_nx  = 1'b1;
          done_nx  = 1'b0;
          err_nx   = 1'b0;
          waddr_nx = '0;
`ifdef LOADER_CSUM_EN
          csum_nx  = 8'h00;
`endif
        end
      end
      L_CNT_LO: begin
        if (rx_valid) begin
          cnt_lo_nx = rx_byte;
          state_nx  = L_CNT_HI;
`ifdef LOADER_CSUM_EN
          csum_nx   = csum_q ^ rx_byte;
`endif
        end
      end
      L_CNT_HI: begin
        if (rx_valid) begin
`ifdef LOADER_CSUM_EN
          csum_nx = csum_q ^ rx_byte;
`endif
          last_idx_nx = ADDR_W'(n_rx - 16'd1);
          byte_idx_nx = '0;
          if (32'(n_rx) > DEPTH) abort = 1'b1;
          else if (n_rx == 16'd0) frame_end = 1'b1;
          else state_nx = L_DATA;
        end
      end
      L_DATA: begin
        // Address advances the cycle after each strobe; the final strobe
        // also ends the data phase.
        if (rom_we) begin
          waddr_nx = rom_waddr + ADDR_W'(1);
          if (rom_waddr == last_idx) frame_end = 1'b1;
        end
        if (rx_valid) begin
          byte_idx_nx = byte_idx + 2'd1;
`ifdef LOADER_CSUM_EN
          csum_nx = csum_q ^ rx_byte;
`endif
          case (byte_idx)
            2'd0:    asm_nx[7:0]   = rx_byte;
            2'd1:    asm_nx[15:8]  = rx_byte;
            2'd2:    asm_nx[23:16] = rx_byte;
            default: begin
              we_nx    = 1'b1;
              wdata_nx = {rx_byte, asm_q};
            end
          endcase
        end
      end
`ifdef LOADER_CSUM_EN
      L_CSUM: begin
        if (rx_valid) begin
          if (rx_byte == csum_q) go_boot = 1'b1;
          else abort = 1'b1;
        end
      end
`endif
      L_BOOT: begin
        boot_cnt_nx = boot_cnt + RC_W'(1);
        if (boot_cnt == RC_W'(RST_CYC - 1)) begin
          state_nx      = L_IDLE;
          core_rst_n_nx = 1'b1;
          hold_nx       = 1'b0;
          busy_nx       = 1'b0;
          done_nx       = 1'b1;
        end
      end
      default: state_nx = L_IDLE;
    endcase

`ifdef LOADER_CSUM_EN
    if (frame_end) state_nx = L_CSUM;
`else
    if (frame_end) go_boot = 1'b1;
`endif

    if (go_boot) begin
      state_nx      = L_BOOT;
      core_rst_n_nx = 1'b0;
      boot_cnt_nx   = '0;
    end

    if (abort || (active && (rx_err || timeout))) begin
      state_nx = L_IDLE;
      err_nx   = 1'b1;
      busy_nx  = 1'b0;
      hold_nx  = 1'b0;
      we_nx    = 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rom_loader.sv
// Testbench for uart_rom_loader: serialises frames onto uart_rx, records ROM
// writes and core-reset activity, and compares against expectations built
// from the frame contents.
module tb_uart_rom_loader;

  localparam int CLK_FREQ    = 1600000;
  localparam int BAUD        = 100000;
  localparam int CPB         = CLK_FREQ / BAUD;
  localparam int ADDR_W      = 12;
  localparam int TIMEOUT_CYC = 400;
  localparam int RST_CYC     = 8;
`ifdef LOADER_CSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  localparam int K_OK = 0, K_BADCSUM = 1, K_STOPERR = 2, K_TIMEOUT = 3, K_OVF = 4, K_GLITCH = 5;

  logic              clk = 1'b0;
  logic              arst_n = 1'b0;
  logic              uart_rx = 1'b1;
  logic              rom_we;
  logic [ADDR_W-1:0] rom_waddr;
  logic [31:0]       rom_wdata;
  logic              hold, core_rst_n, busy, done, err;

  always #5 clk = ~clk;

  uart_rom_loader #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .ADDR_W(ADDR_W),
    .TIMEOUT_CYC(TIMEOUT_CYC), .RST_CYC(RST_CYC)
  ) dut (
    .clk_100MHz(clk), .arst_n(arst_n), .uart_rx(uart_rx),
    .rom_we(rom_we), .rom_waddr(rom_waddr), .rom_wdata(rom_wdata),
    .hold(hold), .core_rst_n(core_rst_n), .busy(busy), .done(done), .err(err)
  );

  int checks = 0;
  int errors = 0;

  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [31:0]       wr_data_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [31:0]       exp_data_q[$];
  logic [7:0]        data_q[$];
  int                rst_low = 0;
  int                hold_bad = 0;

  typedef struct {
    string       name;
    logic [15:0] cnt;
    int          nbytes;
    int          kind;
    int          kpos;
    bit          exp_done;
    bit          exp_err;
  } vec_t;

  vec_t vecs[7];

  // Observe the write port and the core reset away from the active edge.
  always @(negedge clk) begin
    if (rom_we === 1'b1) begin
      wr_addr_q.push_back(rom_waddr);
      wr_data_q.push_back(rom_wdata);
    end
    if (core_rst_n === 1'b0) begin
      rst_low++;
      if (hold !== 1'b1) hold_bad++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sendByte(input logic [7:0] b, input bit bad_stop);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = !bad_stop;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic waitIdle(input string name, input int budget);
    int n = 0;
    while (busy === 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, " busy_cleared"}, {31'd0, busy}, 32'd0);
  endtask

  // Reference: every complete word received before the frame ends or breaks
  // is written, in order, at its word index, unless the count is too large.
  task automatic buildExpected(input logic [15:0] cnt, input int good_bytes);
    exp_addr_q.delete();
    exp_data_q.delete();
    if (int'(cnt) <= (1 << ADDR_W)) begin
      for (int w = 0; w < int'(cnt) && 4 * w + 3 < good_bytes; w++) begin
        exp_addr_q.push_back(w[ADDR_W-1:0]);
        exp_data_q.push_back({data_q[4*w+3], data_q[4*w+2], data_q[4*w+1], data_q[4*w]});
      end
    end
  endtask

  task automatic applyStimulus(input string name, input logic [15:0] cnt, input int nbytes,
                               input int kind, input int kpos, input bit exp_done, input bit exp_err);
    logic [7:0] csum;
    int good;
    int nchk;
    wr_addr_q.delete();
    wr_data_q.delete();
    rst_low  = 0;
    hold_bad = 0;
    csum     = 8'h00;
    good     = nbytes;
    sendByte(8'hA5, 1'b0);
    sendByte(cnt[7:0], 1'b0);
    csum ^= cnt[7:0];
    checkOutput({name, " busy_in_frame"}, {31'd0, busy}, 32'd1);
    checkOutput({name, " hold_in_frame"}, {31'd0, hold}, 32'd1);
    if (kind == K_GLITCH) begin
      uart_rx = 1'b0;
      repeat (CPB / 4) @(negedge clk);
      uart_rx = 1'b1;
      repeat (2 * CPB) @(negedge clk);
    end
    sendByte(cnt[15:8], 1'b0);
    csum ^= cnt[15:8];
    for (int i = 0; i < nbytes; i++) begin
      bit bad;
      bad = (kind == K_STOPERR) && (i == kpos);
      sendByte(data_q[i], bad);
      csum ^= data_q[i];
      if (bad) begin
        good = i;
        break;
      end
    end
    if (CSUM_EN && (kind == K_OK || kind == K_BADCSUM || kind == K_GLITCH))
      sendByte((kind == K_BADCSUM) ? (csum ^ 8'h01) : csum, 1'b0);
    waitIdle(name, TIMEOUT_CYC * 3);
    repeat (4) @(negedge clk);
    buildExpected(cnt, good);
    checkOutput({name, " nwrites"}, wr_data_q.size(), exp_data_q.size());
    nchk = (wr_data_q.size() < exp_data_q.size()) ? wr_data_q.size() : exp_data_q.size();
    for (int i = 0; i < nchk; i++) begin
      checkOutput($sformatf("%s waddr[%0d]", name, i), {20'd0, wr_addr_q[i]}, {20'd0, exp_addr_q[i]});
      checkOutput($sformatf("%s wdata[%0d]", name, i), wr_data_q[i], exp_data_q[i]);
    end
    checkOutput({name, " done"}, {31'd0, done}, {31'd0, exp_done});
    checkOutput({name, " err"}, {31'd0, err}, {31'd0, exp_err});
    checkOutput({name, " hold_after"}, {31'd0, hold}, 32'd0);
    checkOutput({name, " core_rst_n_after"}, {31'd0, core_rst_n}, 32'd1);
    checkOutput({name, " rst_pulse_len"}, rst_low, exp_done ? RST_CYC : 0);
    checkOutput({name, " hold_during_rst"}, hold_bad, 32'd0);
  endtask

  task automatic checkResetValues(input string name);
    checkOutput({name, " rom_we"}, {31'd0, rom_we}, 32'd0);
    checkOutput({name, " rom_waddr"}, {20'd0, rom_waddr}, 32'd0);
    checkOutput({name, " rom_wdata"}, rom_wdata, 32'd0);
    checkOutput({name, " hold"}, {31'd0, hold}, 32'd0);
    checkOutput({name, " core_rst_n"}, {31'd0, core_rst_n}, 32'd1);
    checkOutput({name, " busy"}, {31'd0, busy}, 32'd0);
    checkOutput({name, " done"}, {31'd0, done}, 32'd0);
    checkOutput({name, " err"}, {31'd0, err}, 32'd0);
  endtask

  initial begin
    #(10 * 95000);
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{"bad_csum",   16'd2,     8,  K_BADCSUM, 0, !CSUM_EN, CSUM_EN};
    vecs[1] = '{"timeout",    16'd1,     2,  K_TIMEOUT, 0, 1'b0,     1'b1};
    vecs[2] = '{"stop_err",   16'd2,     8,  K_STOPERR, 5, 1'b0,     1'b1};
    vecs[3] = '{"overflow",   16'h1001,  0,  K_OVF,     0, 1'b0,     1'b1};
    vecs[4] = '{"zero_cnt",   16'd0,     0,  K_OK,      0, 1'b1,     1'b0};
    vecs[5] = '{"glitch",     16'd1,     4,  K_GLITCH,  0, 1'b1,     1'b0};
    vecs[6] = '{"four_words", 16'd4,     16, K_OK,      0, 1'b1,     1'b0};

    arst_n = 1'b0;
    repeat (3) @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    checkResetValues("reset");

    // Reference frame with known words, good and then bad checksum.
    data_q = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    applyStimulus("plan_ok", 16'd2, 8, K_OK, 0, 1'b1, 1'b0);
    if (wr_data_q.size() >= 2) begin
      checkOutput("plan_ok w0_addr", {20'd0, wr_addr_q[0]}, 32'd0);
      checkOutput("plan_ok w0_data", wr_data_q[0], 32'h12345678);
      checkOutput("plan_ok w1_addr", {20'd0, wr_addr_q[1]}, 32'd1);
      checkOutput("plan_ok w1_data", wr_data_q[1], 32'hDEADBEEF);
    end
    applyStimulus("plan_badcsum", 16'd2, 8, K_BADCSUM, 0, !CSUM_EN, CSUM_EN);

    // Reset in the middle of the data phase abandons the frame.
    wr_addr_q.delete();
    wr_data_q.delete();
    sendByte(8'hA5, 1'b0);
    sendByte(8'h02, 1'b0);
    sendByte(8'h00, 1'b0);
    sendByte(8'h11, 1'b0);
    sendByte(8'h22, 1'b0);
    sendByte(8'h33, 1'b0);
    checkOutput("midreset busy_before", {31'd0, busy}, 32'd1);
    arst_n = 1'b0;
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    checkResetValues("midreset");
    sendByte(8'h44, 1'b0);
    sendByte(8'h55, 1'b0);
    sendByte(8'h66, 1'b0);
    sendByte(8'h77, 1'b0);
    sendByte(8'h88, 1'b0);
    repeat (20) @(negedge clk);
    checkOutput("midreset nwrites", wr_data_q.size(), 32'd0);
    checkOutput("midreset busy_after", {31'd0, busy}, 32'd0);
    checkOutput("midreset err_after", {31'd0, err}, 32'd0);

    for (int v = 0; v < 7; v++) begin
      data_q.delete();
      for (int j = 0; j < vecs[v].nbytes; j++) data_q.push_back(8'($urandom));
      applyStimulus(vecs[v].name, vecs[v].cnt, vecs[v].nbytes, vecs[v].kind,
                    vecs[v].kpos, vecs[v].exp_done, vecs[v].exp_err);
    end

    for (int r = 0; r < 3; r++) begin
      logic [15:0] cnt;
      int kind;
      bit ok;
      cnt  = 16'($urandom_range(1, 3));
      kind = ($urandom_range(0, 1) == 1) ? K_BADCSUM : K_OK;
      ok   = (kind == K_OK) || !CSUM_EN;
      data_q.delete();
      for (int j = 0; j < 4 * int'(cnt); j++) data_q.push_back(8'($urandom));
      applyStimulus($sformatf("rand%0d", r), cnt, 4 * int'(cnt), kind, 0, ok, !ok);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
